// File: rtl/rtl_kernel_wizard_1_example_axi_slave_mem_pkg.sv
// Shared definitions for the AXI slave memory: FSM state encodings,
// default geometry and the log2 helper used to size index fields.
package rtl_kernel_wizard_1_example_axi_slave_mem_pkg;

    // Write channel sequencing: address accept, data beats, response.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Read channel sequencing: address accept, RAM fetch, beat presentation.
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    // AXI burst length field width (beats-1).
    localparam int BURST_LEN_BITS = 8;

    // Ceiling log2, usable in constant expressions for parameter-derived widths.
    function automatic int log2_ceil(input int value);
        return $clog2(value);
    endfunction

    // Geometry of the default configuration.
    localparam int DEFAULT_DATA_WIDTH       = 512;
    localparam int DEFAULT_MEM_DEPTH        = 1024;
    localparam int DEFAULT_BYTE_OFFSET_BITS = log2_ceil(DEFAULT_DATA_WIDTH / 8);
    localparam int DEFAULT_INDEX_BITS       = log2_ceil(DEFAULT_MEM_DEPTH);

endpackage

// File: rtl/rtl_kernel_wizard_1_example_axi_slave_mem_ram.sv
// Word-wide storage split into independent byte lanes. One write port with
// byte enables and one registered read port; a read and write of the same
// word in one cycle returns the previous contents.
module rtl_kernel_wizard_1_example_axi_slave_mem_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024,
    parameter int ADDR_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    wr_en,
    input  logic [ADDR_BITS-1:0]    wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_BITS-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int BYTES = DATA_WIDTH / 8;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_rd_reg;

            // Byte lane write; contents are never cleared by reset.
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
            end

            // Registered read; holds its value between fetches so data stays stable.
            always_ff @(posedge clk) begin
                if (srst) begin
                    lane_rd_reg <= 8'h00;
                end else if (rd_en) begin
                    lane_rd_reg <= lane_mem[rd_addr];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/rtl_kernel_wizard_1_example_axi_slave_mem.sv
// AXI4 slave memory with INCR bursts that wrap modulo the memory depth.
// Independent write and read FSMs share a byte-enabled, read-first RAM.
// A sticky protocol_err flags any wlast that disagrees with awlen.
module rtl_kernel_wizard_1_example_axi_slave_mem
    import rtl_kernel_wizard_1_example_axi_slave_mem_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [BURST_LEN_BITS-1:0]       s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [BURST_LEN_BITS-1:0]       s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            protocol_err
);

    localparam int BYTE_OFFSET_BITS = log2_ceil(C_S_AXI_DATA_WIDTH / 8);
    localparam int INDEX_BITS       = log2_ceil(C_MEM_DEPTH);
    localparam logic [INDEX_BITS-1:0]     INDEX_ONE = 1;
    localparam logic [BURST_LEN_BITS-1:0] BEAT_ONE  = 1;

    // Write side state
    w_state_t                  w_state_reg, w_state_next;
    logic [INDEX_BITS-1:0]     w_index_reg, w_index_next;
    logic [BURST_LEN_BITS-1:0] w_len_reg, w_len_next;
    logic [BURST_LEN_BITS-1:0] w_beat_reg, w_beat_next;
    logic                      protocol_err_reg, protocol_err_next;
    logic                      w_last_beat;
    logic                      w_beat_fire;

    // Read side state
    r_state_t                  r_state_reg, r_state_next;
    logic [INDEX_BITS-1:0]     r_index_reg, r_index_next;
    logic [BURST_LEN_BITS-1:0] r_len_reg, r_len_next;
    logic [BURST_LEN_BITS-1:0] r_beat_reg, r_beat_next;
    logic                      r_last_beat;

    // Address bits outside the word index are intentionally ignored.
    logic addr_bits_unused;
    assign addr_bits_unused = ^{s_axi_awaddr, s_axi_araddr};

    assign w_last_beat = (w_beat_reg == w_len_reg);
    assign r_last_beat = (r_beat_reg == r_len_reg);

    // A data beat lands in memory only while accepting data and not in reset,
    // so a reset cycle never disturbs stored contents.
    assign w_beat_fire = (w_state_reg == W_DATA) && s_axi_wvalid && !areset;

    // Write FSM next-state: latch burst on AW, count beats, end on awlen+1.
    always_comb begin
        w_state_next      = w_state_reg;
        w_index_next      = w_index_reg;
        w_len_next        = w_len_reg;
        w_beat_next       = w_beat_reg;
        protocol_err_next = protocol_err_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    w_index_next = s_axi_awaddr[BYTE_OFFSET_BITS +: INDEX_BITS];
                    w_len_next   = s_axi_awlen;
                    w_beat_next  = '0;
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    w_index_next = w_index_reg + INDEX_ONE;
                    w_beat_next  = w_beat_reg + BEAT_ONE;
                    if (s_axi_wlast != w_last_beat) begin
                        protocol_err_next = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write FSM registers; reset abandons any burst without a response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_reg      <= W_IDLE;
            w_index_reg      <= '0;
            w_len_reg        <= '0;
            w_beat_reg       <= '0;
            protocol_err_reg <= 1'b0;
        end else begin
            w_state_reg      <= w_state_next;
            w_index_reg      <= w_index_next;
            w_len_reg        <= w_len_next;
            w_beat_reg       <= w_beat_next;
            protocol_err_reg <= protocol_err_next;
        end
    end

    // Read FSM next-state: fetch one word, present it, advance on handshake.
    always_comb begin
        r_state_next = r_state_reg;
        r_index_next = r_index_reg;
        r_len_next   = r_len_reg;
        r_beat_next  = r_beat_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_index_next = s_axi_araddr[BYTE_OFFSET_BITS +: INDEX_BITS];
                    r_len_next   = s_axi_arlen;
                    r_beat_next  = '0;
                    r_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                r_state_next = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (r_last_beat) begin
                        r_state_next = R_IDLE;
                    end else begin
                        r_index_next = r_index_reg + INDEX_ONE;
                        r_beat_next  = r_beat_reg + BEAT_ONE;
                        r_state_next = R_FETCH;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_reg <= R_IDLE;
            r_index_reg <= '0;
            r_len_reg   <= '0;
            r_beat_reg  <= '0;
        end else begin
            r_state_reg <= r_state_next;
            r_index_reg <= r_index_next;
            r_len_reg   <= r_len_next;
            r_beat_reg  <= r_beat_next;
        end
    end

    rtl_kernel_wizard_1_example_axi_slave_mem_ram #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .DEPTH      (C_MEM_DEPTH),
        .ADDR_BITS  (INDEX_BITS)
    ) u_ram (
        .clk     (aclk),
        .srst    (areset),
        .wr_en   (w_beat_fire),
        .wr_addr (w_index_reg),
        .wr_be   (s_axi_wstrb),
        .wr_data (s_axi_wdata),
        .rd_en   (r_state_reg == R_FETCH),
        .rd_addr (r_index_reg),
        .rd_data (s_axi_rdata)
    );

    assign s_axi_awready = (w_state_reg == W_IDLE);
    assign s_axi_wready  = (w_state_reg == W_DATA);
    assign s_axi_bvalid  = (w_state_reg == W_RESP);
    assign s_axi_arready = (r_state_reg == R_IDLE);
    assign s_axi_rvalid  = (r_state_reg == R_DATA);
    assign s_axi_rlast   = (r_state_reg == R_DATA) && r_last_beat;
    assign protocol_err  = protocol_err_reg;

endmodule

// File: tb/tb_rtl_kernel_wizard_1_example_axi_slave_mem.sv
// Randomized bench for the AXI slave memory. A word-array model tracks
// memory contents and transaction-level channel status; one negedge monitor
// compares handshake signals, read beats and protocol_err every cycle.
module tb_rtl_kernel_wizard_1_example_axi_slave_mem;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           areset;
    logic           s_axi_awvalid, s_axi_awready;
    logic [AW-1:0]  s_axi_awaddr;
    logic [7:0]     s_axi_awlen;
    logic           s_axi_wvalid, s_axi_wready;
    logic [DW-1:0]  s_axi_wdata;
    logic [NB-1:0]  s_axi_wstrb;
    logic           s_axi_wlast;
    logic           s_axi_bvalid, s_axi_bready;
    logic           s_axi_arvalid, s_axi_arready;
    logic [AW-1:0]  s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic           s_axi_rvalid, s_axi_rready;
    logic [DW-1:0]  s_axi_rdata;
    logic           s_axi_rlast;
    logic           protocol_err;

    always #5 clk = ~clk;

    rtl_kernel_wizard_1_example_axi_slave_mem #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_MEM_DEPTH        (DEPTH)
    ) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .protocol_err  (protocol_err)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } rbeat_t;

    logic [DW-1:0] model_mem [DEPTH];
    rbeat_t        exp_r [$];
    logic [DW-1:0] wq_data [$];
    logic [NB-1:0] wq_strb [$];
    bit            w_active, w_data, b_owed, r_active, model_err;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Byte address with random ignored upper and lower bits around the word index.
    function automatic logic [AW-1:0] mk_addr(input int idx);
        logic [31:0] i32;
        i32 = idx;
        return {32'($urandom()), 16'($urandom()), i32[9:0], 6'($urandom_range(0, 63))};
    endfunction

    function automatic void clear_model_status();
        w_active  = 0;
        w_data    = 0;
        b_owed    = 0;
        r_active  = 0;
        model_err = 0;
        exp_r.delete();
    endfunction

    // ---------------- monitor ----------------
    bit            prev_hold = 0;
    logic [DW-1:0] prev_rdata;
    logic          prev_rlast;
    rbeat_t        mon_e;

    always @(negedge clk) begin
        if (!areset) begin
            chk("awready", DW'(s_axi_awready), DW'(!w_active));
            chk("wready", DW'(s_axi_wready), DW'(w_data));
            chk("bvalid", DW'(s_axi_bvalid), DW'(b_owed));
            chk("arready", DW'(s_axi_arready), DW'(!r_active));
            chk("protocol_err", DW'(protocol_err), DW'(model_err));
            if (!s_axi_rvalid) chk("rlast_idle", DW'(s_axi_rlast), '0);
            if (prev_hold) begin
                chk("rvalid_hold", DW'(s_axi_rvalid), DW'(1));
                chk("rdata_hold", s_axi_rdata, prev_rdata);
                chk("rlast_hold", DW'(s_axi_rlast), DW'(prev_rlast));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    chk("unexpected_rbeat", DW'(1), '0);
                end else begin
                    mon_e = exp_r.pop_front();
                    chk("rdata", s_axi_rdata, mon_e.data);
                    chk("rlast", DW'(s_axi_rlast), DW'(mon_e.last));
                end
            end
            prev_hold  = s_axi_rvalid && !s_axi_rready;
            prev_rdata = s_axi_rdata;
            prev_rlast = s_axi_rlast;
        end else begin
            prev_hold = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_awready", DW'(s_axi_awready), DW'(1));
        chk("rst_arready", DW'(s_axi_arready), DW'(1));
        chk("rst_wready", DW'(s_axi_wready), '0);
        chk("rst_bvalid", DW'(s_axi_bvalid), '0);
        chk("rst_rvalid", DW'(s_axi_rvalid), '0);
        chk("rst_rlast", DW'(s_axi_rlast), '0);
        chk("rst_rdata", s_axi_rdata, '0);
        chk("rst_perr", DW'(protocol_err), '0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        areset = 1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_rready = 0; s_axi_wlast = 0;
        clear_model_status();
        @(posedge clk); #1;
        areset = 0;
        check_reset_outputs();
    endtask

    // Write burst; data/strobe come from wq_* when queued, else random/all-ones.
    // bad_beat >= 0 puts wlast on that beat only; abort_beat >= 0 resets there.
    task automatic do_write(input int idx, input int len, input int bad_beat,
                            input int bready_delay, input int abort_beat);
        int cnt;
        int w;
        logic [DW-1:0] d;
        logic [NB-1:0] s;
        s_axi_awvalid = 1;
        s_axi_awaddr  = mk_addr(idx);
        s_axi_awlen   = 8'(len);
        cnt = 0;
        while (!s_axi_awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 50) chk("aw_timeout", DW'(cnt), '0);
        @(posedge clk); #1;
        s_axi_awvalid = 0;
        w_active = 1;
        w_data   = 1;
        w = idx;
        for (int b = 0; b <= len; b++) begin
            if (b == abort_beat) begin
                s_axi_wvalid = 0;
                s_axi_wlast  = 0;
                areset = 1;
                clear_model_status();
                @(posedge clk); #1;
                areset = 0;
                return;
            end
            d = (wq_data.size() > 0) ? wq_data.pop_front() : rand_word();
            s = (wq_strb.size() > 0) ? wq_strb.pop_front() : '1;
            s_axi_wvalid = 1;
            s_axi_wdata  = d;
            s_axi_wstrb  = s;
            s_axi_wlast  = (bad_beat < 0) ? (b == len) : (b == bad_beat);
            cnt = 0;
            while (!s_axi_wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
            if (cnt >= 50) chk("w_timeout", DW'(cnt), '0);
            @(posedge clk); #1;
            for (int k = 0; k < NB; k++) if (s[k]) model_mem[w][k*8 +: 8] = d[k*8 +: 8];
            if (s_axi_wlast != (b == len)) model_err = 1;
            w = (w + 1) % DEPTH;
        end
        s_axi_wvalid = 0;
        s_axi_wlast  = 0;
        w_data = 0;
        b_owed = 1;
        repeat (bready_delay) begin @(posedge clk); #1; end
        s_axi_bready = 1;
        cnt = 0;
        while (!s_axi_bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 50) chk("b_timeout", DW'(cnt), '0);
        @(posedge clk); #1;
        s_axi_bready = 0;
        b_owed   = 0;
        w_active = 0;
        $display("write idx=%0d len=%0d bad_beat=%0d bready_delay=%0d", idx, len, bad_beat, bready_delay);
    endtask

    // Read burst; beat stall_beat is held with rready low for stall_cycles.
    task automatic do_read(input int idx, input int len, input int stall_beat, input int stall_cycles);
        int cnt;
        for (int b = 0; b <= len; b++) exp_r.push_back('{last: (b == len), data: model_mem[(idx + b) % DEPTH]});
        s_axi_arvalid = 1;
        s_axi_araddr  = mk_addr(idx);
        s_axi_arlen   = 8'(len);
        cnt = 0;
        while (!s_axi_arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 50) chk("ar_timeout", DW'(cnt), '0);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        r_active = 1;
        for (int b = 0; b <= len; b++) begin
            cnt = 0;
            while (!s_axi_rvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
            // each beat appears in the second cycle after its AR/R handshake
            chk("rvalid_latency", DW'(cnt), DW'(1));
            if (b == stall_beat) repeat (stall_cycles) begin @(posedge clk); #1; end
            s_axi_rready = 1;
            @(posedge clk); #1;
            s_axi_rready = 0;
        end
        r_active = 0;
        $display("read  idx=%0d len=%0d stall_beat=%0d stall=%0d", idx, len, stall_beat, stall_cycles);
    endtask

    // Single-beat write and read of one word accepted in the same cycle.
    task automatic do_collide(input int idx);
        logic [DW-1:0] nd;
        nd = rand_word();
        exp_r.push_back('{last: 1'b1, data: model_mem[idx]});
        s_axi_awvalid = 1; s_axi_awaddr = mk_addr(idx); s_axi_awlen = 8'd0;
        s_axi_arvalid = 1; s_axi_araddr = mk_addr(idx); s_axi_arlen = 8'd0;
        s_axi_wvalid = 1; s_axi_wdata = nd; s_axi_wstrb = '1; s_axi_wlast = 1;
        chk("collide_idle", DW'({s_axi_awready, s_axi_arready}), DW'(3));
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_arvalid = 0;
        w_active = 1; w_data = 1; r_active = 1;
        @(posedge clk); #1;
        model_mem[idx] = nd;
        s_axi_wvalid = 0; s_axi_wlast = 0;
        w_data = 0; b_owed = 1;
        chk("collide_rvalid", DW'(s_axi_rvalid), DW'(1));
        s_axi_bready = 1; s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0; s_axi_rready = 0;
        b_owed = 0; w_active = 0; r_active = 0;
        $display("collide idx=%0d", idx);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] ff_word, saved41;
    int ridx, rlen;

    initial begin
        areset = 1;
        s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
        s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_rready = 0;
        clear_model_status();
        repeat (3) @(posedge clk);
        #1;
        areset = 0;
        check_reset_outputs();

        // fill the working window so every later read targets known data
        for (int i = 0; i < 64; i += 8) do_write(i, 7, -1, 0, -1);
        do_write(DEPTH - 8, 7, -1, 0, -1);

        // 4-beat burst of 1..4 and readback
        for (int i = 1; i <= 4; i++) begin wq_data.push_back(DW'(i)); wq_strb.push_back('1); end
        do_write(0, 3, -1, 0, -1);
        for (int i = 0; i < 4; i++) chk("pin_seq", model_mem[i], DW'(i + 1));
        do_read(0, 3, -1, 0);

        // byte-strobe merge on word 5
        ff_word = '1;
        wq_data.push_back(ff_word); wq_strb.push_back('1);
        do_write(5, 0, -1, 0, -1);
        wq_data.push_back('0); wq_strb.push_back(NB'(1));
        do_write(5, 0, -1, 0, -1);
        chk("pin_strb", model_mem[5], {{(NB-1){8'hFF}}, 8'h00});
        do_read(5, 0, -1, 0);

        // burst wrapping past the top of memory
        for (int i = 0; i < 4; i++) begin wq_data.push_back(DW'(32'hA0 + i)); wq_strb.push_back('1); end
        do_write(DEPTH - 2, 3, -1, 0, -1);
        chk("pin_wrap0", model_mem[DEPTH-2], DW'(32'hA0));
        chk("pin_wrap1", model_mem[DEPTH-1], DW'(32'hA1));
        chk("pin_wrap2", model_mem[0], DW'(32'hA2));
        chk("pin_wrap3", model_mem[1], DW'(32'hA3));
        do_read(DEPTH - 2, 3, -1, 0);

        // backpressure on R and B
        do_read(0, 3, 1, 5);
        do_write(20, 1, -1, 3, -1);

        // same-cycle read and write of one word
        do_collide(10);
        do_read(10, 0, -1, 0);

        // early wlast: error flag sticky until reset
        do_write(30, 3, 1, 0, -1);
        chk("perr_set", DW'(protocol_err), DW'(1));
        do_write(31, 0, -1, 0, -1);
        chk("perr_sticky", DW'(protocol_err), DW'(1));
        do_reset();

        // reset during the second data beat
        saved41 = model_mem[41];
        do_write(40, 3, -1, 0, 1);
        check_reset_outputs();
        repeat (10) begin @(posedge clk); #1; end
        chk("abort_w41", model_mem[41], saved41);
        do_read(40, 3, -1, 0);

        // randomized traffic within the initialized window
        for (int t = 0; t < 40; t++) begin
            rlen = $urandom_range(0, 7);
            ridx = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 56);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= rlen; b++) begin
                    wq_data.push_back(rand_word());
                    wq_strb.push_back({$urandom(), $urandom()});
                end
                do_write(ridx, rlen, -1, $urandom_range(0, 3), -1);
            end else begin
                do_read(ridx, rlen, $urandom_range(0, 7), $urandom_range(0, 3));
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("exp_r_drained", DW'(exp_r.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rtl_kernel_wizard_1_example_axi_slave_mem.md
RTL_KERNEL_WIZARD_1_EXAMPLE_AXI_SLAVE_MEM -- requirements
Module: rtl_kernel_wizard_1_example_axi_slave_mem

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 64, byte address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 512, data width; multiple of 32.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, word count; power of two.
REQ-004 SHALL use one clock and a synchronous, active-high reset: aclk in 1 is the clock; areset in 1 is the reset.
REQ-005 SHALL have write-address ports: s_axi_awvalid in 1; s_axi_awready out 1; s_axi_awaddr in C_S_AXI_ADDR_WIDTH; s_axi_awlen in 8 (beats-1).
REQ-006 SHALL have write-data ports: s_axi_wvalid in 1; s_axi_wready out 1; s_axi_wdata in DW; s_axi_wstrb in DW/8; s_axi_wlast in 1.
REQ-007 SHALL have write-response ports: s_axi_bvalid out 1; s_axi_bready in 1.
REQ-008 SHALL have read-address ports: s_axi_arvalid in 1; s_axi_arready out 1; s_axi_araddr in C_S_AXI_ADDR_WIDTH; s_axi_arlen in 8.
REQ-009 SHALL have read-data ports: s_axi_rvalid out 1; s_axi_rready in 1; s_axi_rdata out DW; s_axi_rlast out 1.
REQ-010 SHALL have protocol_err out 1: sticky wlast-mismatch flag.

Function
REQ-011 Word index SHALL be addr[LOG2(DW/8) +: LOG2(C_MEM_DEPTH)]; low byte bits and upper bits SHALL be ignored.
REQ-012 Beat index SHALL increment by 1 per beat, wrapping modulo C_MEM_DEPTH (incr burst, no 4 KB check).
REQ-013 Read and write FSMs SHALL run independently and concurrently.
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP: W_IDLE awready=1; AW handshake latches index and awlen, goes to W_DATA.
REQ-015 W_DATA: wready=1; each W handshake writes bytes whose wstrb bit is 1, leaves others unchanged.
REQ-016 Write burst SHALL end on beat awlen+1 regardless of wlast, then go to W_RESP.
REQ-017 wlast asserted on any beat other than beat awlen+1, or deasserted on that beat, SHALL set protocol_err until reset.
REQ-018 W_RESP: bvalid=1 held until bready; on handshake return to W_IDLE; awready SHALL be 0 outside W_IDLE.
REQ-019 Read FSM states R_IDLE, R_FETCH, R_DATA: R_IDLE arready=1; AR handshake latches index and arlen, goes to R_FETCH.
REQ-020 R_FETCH: one-cycle synchronous memory read, go to R_DATA; rvalid=0.
REQ-021 R_DATA: rvalid=1, rdata and rlast stable until rready; rlast=1 only on beat arlen+1.
REQ-022 R_DATA handshake: last beat -> R_IDLE, else index+1 -> R_FETCH (throughput one beat per 2 cycles).
REQ-023 Same-cycle read and write of one word: read SHALL return the old data (read-first).
REQ-024 AR handshake latency to first rvalid SHALL be exactly 2 cycles.
REQ-025 awlen=0 / arlen=0 SHALL yield single-beat bursts with wlast/rlast on beat 1.

Reset
REQ-026 On areset: both FSMs to IDLE; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, protocol_err=0.
REQ-027 Reset mid-burst SHALL abandon the burst, issue no B response, and leave memory contents unchanged by reset.

Structure
REQ-028 Shared package SHALL hold write/read FSM state enums and LOG2 width constants.
REQ-029 Storage SHALL be one sub-module rtl_kernel_wizard_1_example_axi_slave_mem_ram: one write port with byte enables, one registered read port, read-first.

Verification
REQ-030 Write awaddr=0x0, awlen=3, data 1..4, strb all-1; read back same -> rdata 1,2,3,4, rlast on beat 4, one bvalid.
REQ-031 Write word 5 with 0xFF.., then write strb=0x1 data 0x00 -> readback byte0=0x00, other bytes 0xFF.
REQ-032 awaddr=(C_MEM_DEPTH-2)*64, awlen=3 -> words DEPTH-2, DEPTH-1, 0, 1 written; readback confirms wrap.
REQ-033 awlen=3 with wlast on beat 2 -> 4 beats accepted, protocol_err=1, stays 1 until areset.
REQ-034 rready held low 5 cycles during beat 2 -> rvalid, rdata, rlast stable; bready low 3 cycles -> bvalid held.
REQ-035 areset pulsed during W_DATA beat 2 -> bvalid never asserts, all outputs at reset values next cycle.
